// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin arbiter sharing one iterative divider between requesters
//
// div: restoring unsigned divider, one quotient bit per clock.
//   valid_in    in   start a divide (restarts any divide in progress)
//   dividend    in   DIVIDEND_WIDTH operand
//   divisor     in   DIVISOR_WIDTH operand
//   valid_out   out  one-cycle strobe, DIVIDEND_WIDTH+1 cycles after valid_in
//   quotient    out  DIVIDEND_WIDTH result
//   remainder   out  DIVISOR_WIDTH result
//   overflow    out  divisor was zero
//
// div_arbiter: grants one requester at a time in round-robin order, issues a
// single divide for it and routes the result back as a one-cycle strobe.
//   clk, reset      clock; asynchronous active-low reset
//   req_valid       per requester: operands ready
//   req_ready       one-hot grant, combinational in IDLE
//   req_dividend    packed dividends, slice i per requester
//   req_divisor     packed divisors, slice i per requester
//   resp_valid      one-hot one-cycle result strobe to the owner
//   resp_quotient   quotient, held until the next response
//   resp_remainder  remainder, held until the next response
//   resp_overflow   divider overflow, divide-by-zero or watchdog
//   resp_timeout    response forced by the watchdog
//   busy            arbiter not idle

module div #(
    parameter int DIVIDEND_WIDTH = 64,
    parameter int DIVISOR_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid_in,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      valid_out,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      overflow
);
    localparam int DW    = DIVIDEND_WIDTH;
    localparam int SW    = DIVISOR_WIDTH;
    localparam int CNT_W = $clog2(DW + 1);

    // dq holds the not-yet-consumed dividend bits at the top and the
    // quotient bits produced so far at the bottom.
    logic [DW-1:0]    dq_q, dq_d;
    logic [SW-1:0]    rem_q, rem_d;
    logic [SW-1:0]    dsr_q, dsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic [SW:0]      rem_shift;

    always_comb begin
        dq_d      = dq_q;
        rem_d     = rem_q;
        dsr_d     = dsr_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        rem_shift = {rem_q, dq_q[DW-1]};
        if (valid_in) begin
            dq_d  = dividend;
            rem_d = '0;
            dsr_d = divisor;
            cnt_d = CNT_W'(DW);
            ovf_d = (divisor == '0);
        end else if (cnt_q != '0) begin
            // Partial remainder stays below the divisor, so the difference
            // always fits in SW bits even when rem_shift needs SW+1.
            if (rem_shift >= {1'b0, dsr_q}) begin
                rem_d = rem_shift[SW-1:0] - dsr_q;
                dq_d  = {dq_q[DW-2:0], 1'b1};
            end else begin
                rem_d = rem_shift[SW-1:0];
                dq_d  = {dq_q[DW-2:0], 1'b0};
            end
            cnt_d  = cnt_q - CNT_W'(1);
            done_d = (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dq_q   <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            dq_q   <= dq_d;
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
        end
    end

    assign valid_out = done_q;
    assign quotient  = dq_q;
    assign remainder = rem_q;
    assign overflow  = ovf_q;
endmodule

module div_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int DIVIDEND_WIDTH = 64,
    parameter int DIVISOR_WIDTH  = 32,
    parameter int TIMEOUT        = 128
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0] req_dividend,
    input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]  req_divisor,
    output logic [NUM_REQ-1:0]                resp_valid,
    output logic [DIVIDEND_WIDTH-1:0]         resp_quotient,
    output logic [DIVISOR_WIDTH-1:0]          resp_remainder,
    output logic                              resp_overflow,
    output logic                              resp_timeout,
    output logic                              busy
);
    localparam int DW    = DIVIDEND_WIDTH;
    localparam int SW    = DIVISOR_WIDTH;
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int SUM_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [DW-1:0]    dividend_q, dividend_d;
    logic [SW-1:0]    divisor_q, divisor_d;
    logic [DW-1:0]    quot_q, quot_d;
    logic [SW-1:0]    rem_q, rem_d;
    logic             ovf_q, ovf_d;
    logic             tmo_q, tmo_d;

    logic             div_valid_in;
    logic             div_valid_out;
    logic [DW-1:0]    div_quotient;
    logic [SW-1:0]    div_remainder;
    logic             div_overflow;

    logic             grant_found;
    logic [PTR_W-1:0] grant_idx;
    logic [SUM_W-1:0] cand;
    logic [DW-1:0]    sel_dividend;
    logic [SW-1:0]    sel_divisor;
    logic [NUM_REQ-1:0] ready_c;

    // Round-robin search starting at rr_ptr; the extra sum bit lets the
    // wrap work for requester counts that are not a power of two.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + SUM_W'(k);
            if (cand >= SUM_W'(NUM_REQ)) begin
                cand = cand - SUM_W'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    assign sel_dividend = req_dividend[int'(grant_idx)*DW +: DW];
    assign sel_divisor  = req_divisor[int'(grant_idx)*SW +: SW];

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        timer_d      = timer_q;
        dividend_d   = dividend_q;
        divisor_d    = divisor_q;
        quot_d       = quot_q;
        rem_d        = rem_q;
        ovf_d        = ovf_q;
        tmo_d        = tmo_q;
        ready_c      = '0;
        resp_valid   = '0;
        div_valid_in = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    ready_c[grant_idx] = 1'b1;
                    owner_d            = grant_idx;
                    dividend_d         = sel_dividend;
                    divisor_d          = sel_divisor;
                    if (sel_divisor == '0) begin
                        // Answer divide-by-zero locally; the divider stays free.
                        quot_d  = '1;
                        rem_d   = '0;
                        ovf_d   = 1'b1;
                        tmo_d   = 1'b0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                div_valid_in = 1'b1;
                timer_d      = '0;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_valid_out) begin
                    quot_d  = div_quotient;
                    rem_d   = div_remainder;
                    ovf_d   = div_overflow;
                    tmo_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    quot_d  = '0;
                    rem_d   = '0;
                    ovf_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_RESP: begin
                resp_valid[owner_q] = 1'b1;
                rr_ptr_d = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            timer_q    <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            timer_q    <= timer_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            ovf_q      <= ovf_d;
            tmo_q      <= tmo_d;
        end
    end

    // The grant is combinational from req_valid, so hold it low while in reset.
    assign req_ready      = ready_c & {NUM_REQ{reset}};
    assign resp_quotient  = quot_q;
    assign resp_remainder = rem_q;
    assign resp_overflow  = ovf_q;
    assign resp_timeout   = tmo_q;
    assign busy           = (state_q != ST_IDLE);

    div #(
        .DIVIDEND_WIDTH(DW),
        .DIVISOR_WIDTH (SW)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .valid_in (div_valid_in),
        .dividend (dividend_q),
        .divisor  (divisor_q),
        .valid_out(div_valid_out),
        .quotient (div_quotient),
        .remainder(div_remainder),
        .overflow (div_overflow)
    );
endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - directed and scoreboard bench for div_arbiter
module tb_div_arbiter;
    localparam int NR = 3;
    localparam int DW = 64;
    localparam int SW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid, req_ready, resp_valid;
    logic [NR*DW-1:0] req_dividend;
    logic [NR*SW-1:0] req_divisor;
    logic [DW-1:0]   resp_quotient;
    logic [SW-1:0]   resp_remainder;
    logic            resp_overflow, resp_timeout, busy;

    logic [1:0]      t_req_valid, t_req_ready, t_resp_valid;
    logic [2*DW-1:0] t_req_dividend;
    logic [2*SW-1:0] t_req_divisor;
    logic [DW-1:0]   t_resp_quotient;
    logic [SW-1:0]   t_resp_remainder;
    logic            t_resp_overflow, t_resp_timeout, t_busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [NR-1:0] own;
        logic [DW-1:0] q;
        logic [SW-1:0] r;
        logic          o;
    } exp_t;

    always #5 clk = ~clk;

    div_arbiter #(.NUM_REQ(NR), .DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(SW), .TIMEOUT(128)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor), .resp_valid(resp_valid),
        .resp_quotient(resp_quotient), .resp_remainder(resp_remainder),
        .resp_overflow(resp_overflow), .resp_timeout(resp_timeout), .busy(busy)
    );

    div_arbiter #(.NUM_REQ(2), .DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(SW), .TIMEOUT(8)) dut_to (
        .clk(clk), .reset(reset), .req_valid(t_req_valid), .req_ready(t_req_ready),
        .req_dividend(t_req_dividend), .req_divisor(t_req_divisor), .resp_valid(t_resp_valid),
        .resp_quotient(t_resp_quotient), .resp_remainder(t_resp_remainder),
        .resp_overflow(t_resp_overflow), .resp_timeout(t_resp_timeout), .busy(t_busy)
    );

    task automatic set_op(input int i, input logic [DW-1:0] dvd, input logic [SW-1:0] dvs);
        req_dividend[i*DW +: DW] = dvd;
        req_divisor[i*SW +: SW]  = dvs;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        req_valid = '0;
        t_req_valid = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Called at posedge+1 of the grant cycle; cycles=0 means no response in time.
    task automatic wait_resp(input int limit, output int cycles, output int vins);
        cycles = 0;
        vins = 0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (dut.div_valid_in) vins++;
            if (resp_valid != '0) begin
                cycles = c;
                break;
            end
        end
    endtask

    function automatic logic [NR-1:0] model_winner(input logic [NR-1:0] v, input int rr);
        logic [NR-1:0] w;
        int idx;
        w = '0;
        for (int k = 0; k < NR; k++) begin
            idx = (rr + k) % NR;
            if (w == '0 && v[idx]) w[idx] = 1'b1;
        end
        return w;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '1;
        req_dividend = '1;
        req_divisor = '1;
        t_req_valid = '1;
        t_req_dividend = '1;
        t_req_divisor = '1;
        #2 reset = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL rst_req_ready: got %b expected 000", req_ready); end
        checks++; if (t_req_ready !== 2'b00) begin errors++; $display("FAIL rst_t_req_ready: got %b expected 00", t_req_ready); end
        checks++; if (resp_valid !== 3'b000) begin errors++; $display("FAIL rst_resp_valid: got %b expected 000", resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if ({resp_quotient, resp_remainder} !== 96'd0) begin errors++; $display("FAIL rst_results: got %h/%h expected 0/0", resp_quotient, resp_remainder); end
        checks++; if ({resp_overflow, resp_timeout} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b expected 00", {resp_overflow, resp_timeout}); end
        checks++; if (dut.div_valid_in !== 1'b0) begin errors++; $display("FAIL rst_div_valid_in: got %b expected 0", dut.div_valid_in); end
        do_reset();
        @(negedge clk);
        checks++; if ({busy, resp_valid} !== 4'b0000) begin errors++; $display("FAIL rst_release_idle: got %b expected 0000", {busy, resp_valid}); end
    endtask

    task automatic test_rr();
        int cyc, vins;
        do_reset();
        set_op(0, 64'd100, 32'd7);
        set_op(1, 64'd1000, 32'd9);
        req_valid = 3'b011;
        @(negedge clk);
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL rr_first_grant: got %b expected 001", req_ready); end
        @(posedge clk); #1;
        set_op(0, 64'd50, 32'd6);
        wait_resp(200, cyc, vins);
        checks++; if (cyc !== 67) begin errors++; $display("FAIL rr_lat0: got %0d expected 67", cyc); end
        checks++; if (resp_valid !== 3'b001) begin errors++; $display("FAIL rr_owner0: got %b expected 001", resp_valid); end
        checks++; if ({resp_quotient, resp_remainder} !== {64'd14, 32'd2}) begin errors++; $display("FAIL rr_result0: got %0d/%0d expected 14/2", resp_quotient, resp_remainder); end
        @(negedge clk);
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL rr_rotate: got %b expected 010", req_ready); end
        @(posedge clk); #1;
        req_valid = 3'b001;
        wait_resp(200, cyc, vins);
        checks++; if (resp_valid !== 3'b010) begin errors++; $display("FAIL rr_owner1: got %b expected 010", resp_valid); end
        checks++; if ({resp_quotient, resp_remainder} !== {64'd111, 32'd1}) begin errors++; $display("FAIL rr_result1: got %0d/%0d expected 111/1", resp_quotient, resp_remainder); end
        @(negedge clk);
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL rr_wrap: got %b expected 001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        wait_resp(200, cyc, vins);
        checks++; if (resp_valid !== 3'b001) begin errors++; $display("FAIL rr_owner2: got %b expected 001", resp_valid); end
        checks++; if ({resp_quotient, resp_remainder} !== {64'd8, 32'd2}) begin errors++; $display("FAIL rr_result2: got %0d/%0d expected 8/2", resp_quotient, resp_remainder); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int cyc, vins;
        set_op(0, 64'd1024000, 32'd3000);
        req_valid = 3'b001;
        @(negedge clk);
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL single_ready: got %b expected 001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        wait_resp(200, cyc, vins);
        checks++; if (cyc !== 67) begin errors++; $display("FAIL single_latency: got %0d expected 67", cyc); end
        checks++; if (vins !== 1) begin errors++; $display("FAIL single_issue_count: got %0d expected 1", vins); end
        checks++; if (resp_valid !== 3'b001) begin errors++; $display("FAIL single_owner: got %b expected 001", resp_valid); end
        checks++; if (resp_quotient !== 64'd341) begin errors++; $display("FAIL single_quotient: got %0d expected 341", resp_quotient); end
        checks++; if (resp_remainder !== 32'd1000) begin errors++; $display("FAIL single_remainder: got %0d expected 1000", resp_remainder); end
        checks++; if ({resp_overflow, resp_timeout} !== 2'b00) begin errors++; $display("FAIL single_flags: got %b expected 00", {resp_overflow, resp_timeout}); end
        @(negedge clk);
        checks++; if ({busy, resp_valid} !== 4'b0000) begin errors++; $display("FAIL single_strobe_end: got %b expected 0000", {busy, resp_valid}); end
        checks++; if (resp_quotient !== 64'd341) begin errors++; $display("FAIL single_hold: got %0d expected 341", resp_quotient); end
        @(posedge clk); #1;
    endtask

    task automatic test_div_zero();
        int cyc, vins;
        set_op(1, 64'd12345, 32'd0);
        req_valid = 3'b010;
        @(negedge clk);
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL dz_ready: got %b expected 010", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        wait_resp(10, cyc, vins);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL dz_latency: got %0d expected 1", cyc); end
        checks++; if (vins !== 0) begin errors++; $display("FAIL dz_no_issue: got %0d expected 0", vins); end
        checks++; if (resp_valid !== 3'b010) begin errors++; $display("FAIL dz_owner: got %b expected 010", resp_valid); end
        checks++; if (resp_quotient !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL dz_quotient: got %h expected all ones", resp_quotient); end
        checks++; if (resp_remainder !== 32'd0) begin errors++; $display("FAIL dz_remainder: got %h expected 0", resp_remainder); end
        checks++; if ({resp_overflow, resp_timeout} !== 2'b10) begin errors++; $display("FAIL dz_flags: got %b expected 10", {resp_overflow, resp_timeout}); end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int issue_c, resp_c, late_c, stray;
        t_req_dividend = {64'd0, 64'd100};
        t_req_divisor = {32'd0, 32'd7};
        t_req_valid = 2'b01;
        @(negedge clk);
        checks++; if (t_req_ready !== 2'b01) begin errors++; $display("FAIL to_ready: got %b expected 01", t_req_ready); end
        @(posedge clk); #1;
        t_req_valid = '0;
        issue_c = 0;
        resp_c = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (dut_to.div_valid_in && issue_c == 0) issue_c = c;
            if (t_resp_valid != '0) begin
                resp_c = c;
                break;
            end
        end
        checks++; if (issue_c !== 1) begin errors++; $display("FAIL to_issue_cycle: got %0d expected 1", issue_c); end
        checks++; if (resp_c !== 10) begin errors++; $display("FAIL to_resp_cycle: got %0d expected 10", resp_c); end
        checks++; if (t_resp_valid !== 2'b01) begin errors++; $display("FAIL to_owner: got %b expected 01", t_resp_valid); end
        checks++; if ({t_resp_quotient, t_resp_remainder} !== 96'd0) begin errors++; $display("FAIL to_results: got %h/%h expected 0/0", t_resp_quotient, t_resp_remainder); end
        checks++; if ({t_resp_overflow, t_resp_timeout} !== 2'b11) begin errors++; $display("FAIL to_flags: got %b expected 11", {t_resp_overflow, t_resp_timeout}); end
        late_c = 0;
        stray = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (t_resp_valid != '0) stray++;
            if (dut_to.div_valid_out) begin
                late_c = c;
                break;
            end
        end
        checks++; if (late_c == 0) begin errors++; $display("FAIL to_late_result_seen: got none expected a late valid_out"); end
        checks++; if (t_busy !== 1'b0) begin errors++; $display("FAIL to_late_busy: got %b expected 0", t_busy); end
        @(negedge clk);
        checks++; if (stray !== 0 || t_resp_valid !== 2'b00) begin errors++; $display("FAIL to_late_ignored: got %0d strobes expected 0", stray); end
        checks++; if ({t_resp_quotient, t_resp_timeout} !== {64'd0, 1'b1}) begin errors++; $display("FAIL to_late_hold: got %0d/%b expected 0/1", t_resp_quotient, t_resp_timeout); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int cyc, vins, stray;
        set_op(2, 64'd999, 32'd10);
        req_valid = 3'b100;
        @(negedge clk);
        checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL rm_ready: got %b expected 100", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if ({busy, resp_valid, req_ready, dut.div_valid_in} !== 8'd0) begin errors++; $display("FAIL rm_outputs: got %b expected 0", {busy, resp_valid, req_ready, dut.div_valid_in}); end
        checks++; if ({resp_quotient, resp_remainder, resp_overflow, resp_timeout} !== 98'd0) begin errors++; $display("FAIL rm_results: got %h expected 0", resp_quotient); end
        @(posedge clk); #1;
        reset = 1'b1;
        stray = 0;
        for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            if (resp_valid != '0 || busy) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL rm_abandoned: got %0d active cycles expected 0", stray); end
        @(posedge clk); #1;
        set_op(0, 64'd300, 32'd7);
        req_valid = 3'b001;
        @(negedge clk);
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL rm_new_ready: got %b expected 001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        wait_resp(200, cyc, vins);
        checks++; if (cyc !== 67) begin errors++; $display("FAIL rm_new_latency: got %0d expected 67", cyc); end
        checks++; if ({resp_valid, resp_quotient, resp_remainder} !== {3'b001, 64'd42, 32'd6}) begin errors++; $display("FAIL rm_new_result: got %b %0d/%0d expected 001 42/6", resp_valid, resp_quotient, resp_remainder); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] op_dvd [NR];
        logic [SW-1:0] op_dvs [NR];
        logic [DW-1:0] tmp;
        logic [NR-1:0] win, granted;
        exp_t sb[$];
        exp_t e;
        int rr, issued, served, cyc;
        do_reset();
        rr = 0;
        issued = 0;
        served = 0;
        cyc = 0;
        while (served < 24 && cyc < 4000) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && issued + $countones(req_valid) < 24 && $urandom_range(0, 3) != 0) begin
                    op_dvd[i] = {$urandom, $urandom};
                    if ($urandom_range(0, 1) == 0) op_dvd[i] = op_dvd[i] >> $urandom_range(1, 60);
                    case ($urandom_range(0, 9))
                        0:       op_dvs[i] = '0;
                        1, 2:    op_dvs[i] = SW'($urandom_range(1, 255));
                        default: op_dvs[i] = $urandom;
                    endcase
                    set_op(i, op_dvd[i], op_dvs[i]);
                    req_valid[i] = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
            win = model_winner(req_valid, rr);
            if (req_ready != '0) begin
                checks++; if (req_ready !== win) begin errors++; $display("FAIL b2b_grant: got %b expected %b", req_ready, win); end
                for (int i = 0; i < NR; i++) begin
                    if (req_ready[i]) begin
                        e.own = '0;
                        e.own[i] = 1'b1;
                        if (op_dvs[i] == '0) begin
                            e.q = '1;
                            e.r = '0;
                            e.o = 1'b1;
                        end else begin
                            e.q = op_dvd[i] / {32'd0, op_dvs[i]};
                            tmp = op_dvd[i] % {32'd0, op_dvs[i]};
                            e.r = tmp[SW-1:0];
                            e.o = 1'b0;
                        end
                        sb.push_back(e);
                        issued++;
                    end
                end
            end
            if (resp_valid != '0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL b2b_stray_resp: got %b expected none", resp_valid);
                end else begin
                    e = sb.pop_front();
                    served++;
                    if (resp_valid !== e.own || resp_quotient !== e.q || resp_remainder !== e.r || resp_overflow !== e.o || resp_timeout !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b_resp: got %b %h/%h o%b t%b expected %b %h/%h o%b t0", resp_valid, resp_quotient, resp_remainder, resp_overflow, resp_timeout, e.own, e.q, e.r, e.o);
                    end
                    for (int i = 0; i < NR; i++) if (e.own[i]) rr = (i + 1) % NR;
                end
            end
            granted = req_ready;
            @(posedge clk); #1;
            req_valid = req_valid & ~granted;
        end
        checks++; if (served !== 24 || issued !== 24) begin errors++; $display("FAIL b2b_count: got %0d served %0d issued expected 24", served, issued); end
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL b2b_leftover: got %0d expected 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_rr();
        test_single();
        test_div_zero();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
